evm_ballot_controller: RTL and testbench

//  Presiding-officer side of the EVM port set: powers the evm, admits one voter per token
//  via a candidate_ready pulse, then closes the session.

---
 rtl/evm_pkg.sv | 34 +++
 rtl/evm_ballot_controller_if.sv | 60 ++++++
 rtl/evm_token_counter.sv | 47 ++++
 rtl/evm_ballot_controller.sv | 269 ++++++++++++++++++++++++++
 tb/tb_evm_ballot_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot controller.
//   - controller state codes (plain 4-bit constants)
//   - candidate codes reported by the evm on candidate_name
//   - tally select codes driven on display_results
//   - evm internal idle/vote timeout length, for models of the evm side
package evm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StOff    = 4'd0;
    localparam state_t StPwrUp  = 4'd1;
    localparam state_t StOpen   = 4'd2;
    localparam state_t StAdmit  = 4'd3;
    localparam state_t StWaitV  = 4'd4;
    localparam state_t StClose  = 4'd5;
    localparam state_t StRead   = 4'd6;
    localparam state_t StWinner = 4'd7;
    localparam state_t StReport = 4'd8;
    localparam state_t StPwrOff = 4'd9;

    localparam logic [1:0] CAND_1 = 2'b01;
    localparam logic [1:0] CAND_2 = 2'b10;
    localparam logic [1:0] CAND_3 = 2'b11;

    localparam logic [1:0] DISP_C1 = 2'b00;
    localparam logic [1:0] DISP_C2 = 2'b01;
    localparam logic [1:0] DISP_C3 = 2'b10;

    localparam int unsigned EVM_TIMER_MAX = 100;

    // Cycles spent in PWRUP before the session opens.
    localparam int unsigned PWRUP_CYCLES = 2;

endpackage

// File: rtl/evm_ballot_controller_if.sv
// Signal bundle between the ballot controller, the officer console and the evm.
//   master : controller side (drives evm control + console report)
//   slave  : environment side (console pulses + evm status/results)
// Console -> controller : start_session, voter_token, close_session
// Controller -> evm     : switch_on_evm, candidate_ready, voting_session_done,
//                         display_results, display_winner
// Evm -> controller     : voting_in_progress, voting_done, invalid_results,
//                         results, candidate_name
// Controller -> console : tally_1/2/3, winner_id, tie_flag, admitted, abandoned,
//                         autoclosed, report_valid, error
interface evm_ballot_controller_if #(
    parameter int unsigned WIDTH = 7
);

    logic             start_session;
    logic             voter_token;
    logic             close_session;

    logic             switch_on_evm;
    logic             candidate_ready;
    logic             voting_session_done;
    logic [1:0]       display_results;
    logic             display_winner;

    logic             voting_in_progress;
    logic             voting_done;
    logic             invalid_results;
    logic [WIDTH-1:0] results;
    logic [1:0]       candidate_name;

    logic [WIDTH-1:0] tally_1;
    logic [WIDTH-1:0] tally_2;
    logic [WIDTH-1:0] tally_3;
    logic [1:0]       winner_id;
    logic             tie_flag;
    logic [WIDTH-1:0] admitted;
    logic [WIDTH-1:0] abandoned;
    logic             autoclosed;
    logic             report_valid;
    logic             error;

    modport master (
        input  start_session, voter_token, close_session,
        input  voting_in_progress, voting_done, invalid_results, results, candidate_name,
        output switch_on_evm, candidate_ready, voting_session_done, display_results,
        output display_winner,
        output tally_1, tally_2, tally_3, winner_id, tie_flag, admitted, abandoned,
        output autoclosed, report_valid, error
    );

    modport slave (
        output start_session, voter_token, close_session,
        output voting_in_progress, voting_done, invalid_results, results, candidate_name,
        input  switch_on_evm, candidate_ready, voting_session_done, display_results,
        input  display_winner,
        input  tally_1, tally_2, tally_3, winner_id, tie_flag, admitted, abandoned,
        input  autoclosed, report_valid, error
    );

endinterface

// File: rtl/evm_token_counter.sv
// Saturating up/down counter for pending voter tokens.
//   clk, rst  : clock, synchronous active-high reset
//   inc_i     : count up (held at all-ones)
//   dec_i     : count down (held at zero)
//   clr_i     : clear to zero, overrides inc/dec
//   count_o   : current count
// Simultaneous inc and dec leave the count unchanged.
module evm_token_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (count_q != '1) begin
                count_d = count_q + Width'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - Width'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/evm_ballot_controller.sv
// Presiding-officer controller for an EVM: powers the evm, admits one voter per
// console token, closes the session, reads back the three tallies and the winner
// and holds a report for the officer console.
//   clk, rst : clock, synchronous active-high reset (drops evm power)
//   bus_io   : master side of evm_ballot_controller_if (console + evm signals)
// Parameters: WIDTH tally width, TOKEN_BITS pending-token counter width,
// ACK_TIMEOUT cycles allowed for each evm handshake edge.
module evm_ballot_controller
    import evm_pkg::*;
#(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned TOKEN_BITS  = 4,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    evm_ballot_controller_if.master bus_io
);

    localparam logic [7:0]       PwrUpLast = 8'(PWRUP_CYCLES - 1);
    localparam logic [7:0]       AckLast   = 8'(ACK_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] CountMax  = '1;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             seen_q, seen_d;     // voting_in_progress rise seen in WAITV
    logic [1:0]       rd_idx_q, rd_idx_d;
    logic             close_q, close_d;   // close request waiting for next OPEN
    logic [WIDTH-1:0] tally_1_q, tally_1_d;
    logic [WIDTH-1:0] tally_2_q, tally_2_d;
    logic [WIDTH-1:0] tally_3_q, tally_3_d;
    logic [1:0]       winner_q, winner_d;
    logic             tie_q, tie_d;
    logic [WIDTH-1:0] admitted_q, admitted_d;
    logic [WIDTH-1:0] abandoned_q, abandoned_d;
    logic             autoclosed_q, autoclosed_d;
    logic             error_q, error_d;

    logic [TOKEN_BITS-1:0] pending;
    logic                  tok_inc;
    logic                  tok_dec;
    logic                  tok_clr;

    logic [WIDTH+1:0] tally_sum;
    logic [WIDTH+1:0] admitted_ext;
    logic [WIDTH+1:0] abandoned_raw;
    logic [WIDTH-1:0] abandoned_calc;

    // Tokens arriving once polling is closed belong to no session.
    assign tok_inc = bus_io.voter_token &&
                     !(state_q inside {StClose, StRead, StWinner, StReport});
    assign tok_dec = (state_q == StAdmit);

    evm_token_counter #(
        .Width (TOKEN_BITS)
    ) u_token_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (tok_inc),
        .dec_i   (tok_dec),
        .clr_i   (tok_clr),
        .count_o (pending)
    );

    // Extra two bits hold the three-way tally sum without overflow.
    always_comb begin
        tally_sum     = {2'b00, tally_1_q} + {2'b00, tally_2_q} + {2'b00, tally_3_q};
        admitted_ext  = {2'b00, admitted_q};
        abandoned_raw = (admitted_ext > tally_sum) ? admitted_ext - tally_sum : '0;
        if (abandoned_raw > {2'b00, CountMax}) begin
            abandoned_calc = CountMax;
        end else begin
            abandoned_calc = abandoned_raw[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        seen_d       = seen_q;
        rd_idx_d     = rd_idx_q;
        close_d      = close_q;
        tally_1_d    = tally_1_q;
        tally_2_d    = tally_2_q;
        tally_3_d    = tally_3_q;
        winner_d     = winner_q;
        tie_d        = tie_q;
        admitted_d   = admitted_q;
        abandoned_d  = abandoned_q;
        autoclosed_d = autoclosed_q;
        error_d      = error_q;
        tok_clr      = 1'b0;

        if (bus_io.close_session && (state_q inside {StOpen, StAdmit, StWaitV})) begin
            close_d = 1'b1;
        end

        case (state_q)
            StOff: begin
                if (bus_io.start_session) begin
                    state_d = StPwrUp;
                    timer_d = '0;
                    error_d = 1'b0;
                end
            end
            StPwrUp: begin
                if (timer_q == PwrUpLast) begin
                    state_d = StOpen;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StOpen: begin
                if (bus_io.voting_done) begin
                    // evm idle-timed out and closed itself
                    state_d      = StRead;
                    rd_idx_d     = DISP_C1;
                    autoclosed_d = 1'b1;
                    close_d      = 1'b0;
                    tok_clr      = 1'b1;
                end else if ((bus_io.close_session || close_q) &&
                             !bus_io.voting_in_progress) begin
                    state_d = StClose;
                    timer_d = '0;
                    close_d = 1'b0;
                    tok_clr = 1'b1;
                end else if ((pending != '0) && !bus_io.close_session && !close_q) begin
                    state_d = StAdmit;
                end
            end
            StAdmit: begin
                if (admitted_q != CountMax) begin
                    admitted_d = admitted_q + WIDTH'(1);
                end
                state_d = StWaitV;
                timer_d = '0;
                seen_d  = 1'b0;
            end
            StWaitV: begin
                if (!seen_q) begin
                    if (bus_io.voting_in_progress) begin
                        seen_d = 1'b1;
                    end else if (timer_q == AckLast) begin
                        error_d = 1'b1;
                        state_d = StOpen;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end else if (!bus_io.voting_in_progress) begin
                    // vote cast or evm vote timeout; either way the booth is free
                    state_d = StOpen;
                end
            end
            StClose: begin
                if (bus_io.voting_done) begin
                    state_d  = StRead;
                    rd_idx_d = DISP_C1;
                end else if (timer_q == AckLast) begin
                    error_d  = 1'b1;
                    state_d  = StRead;
                    rd_idx_d = DISP_C1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StRead: begin
                // A tie invalidates every tally, including ones already captured.
                if (bus_io.invalid_results || tie_q) begin
                    tie_d     = 1'b1;
                    tally_1_d = '0;
                    tally_2_d = '0;
                    tally_3_d = '0;
                end else begin
                    case (rd_idx_q)
                        DISP_C1: tally_1_d = bus_io.results;
                        DISP_C2: tally_2_d = bus_io.results;
                        default: tally_3_d = bus_io.results;
                    endcase
                end
                if (rd_idx_q == DISP_C3) begin
                    state_d = StWinner;
                end else begin
                    rd_idx_d = rd_idx_q + 2'd1;
                end
            end
            StWinner: begin
                winner_d    = tie_q ? 2'b00 : bus_io.candidate_name;
                abandoned_d = abandoned_calc;
                state_d     = StReport;
            end
            StReport: begin
                if (bus_io.start_session) begin
                    state_d = StPwrOff;
                    error_d = 1'b0;
                end
            end
            StPwrOff: begin
                tally_1_d    = '0;
                tally_2_d    = '0;
                tally_3_d    = '0;
                winner_d     = '0;
                tie_d        = 1'b0;
                admitted_d   = '0;
                abandoned_d  = '0;
                autoclosed_d = 1'b0;
                error_d      = 1'b0;
                close_d      = 1'b0;
                state_d      = StPwrUp;
                timer_d      = '0;
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StOff;
            timer_q      <= '0;
            seen_q       <= 1'b0;
            rd_idx_q     <= '0;
            close_q      <= 1'b0;
            tally_1_q    <= '0;
            tally_2_q    <= '0;
            tally_3_q    <= '0;
            winner_q     <= '0;
            tie_q        <= 1'b0;
            admitted_q   <= '0;
            abandoned_q  <= '0;
            autoclosed_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            seen_q       <= seen_d;
            rd_idx_q     <= rd_idx_d;
            close_q      <= close_d;
            tally_1_q    <= tally_1_d;
            tally_2_q    <= tally_2_d;
            tally_3_q    <= tally_3_d;
            winner_q     <= winner_d;
            tie_q        <= tie_d;
            admitted_q   <= admitted_d;
            abandoned_q  <= abandoned_d;
            autoclosed_q <= autoclosed_d;
            error_q      <= error_d;
        end
    end

    // Power is off only while idle and during the one-cycle power cycle.
    assign bus_io.switch_on_evm       = !(state_q inside {StOff, StPwrOff});
    assign bus_io.candidate_ready     = (state_q == StAdmit);
    assign bus_io.voting_session_done = (state_q == StClose);
    assign bus_io.display_results     = (state_q == StRead) ? rd_idx_q : 2'b00;
    assign bus_io.display_winner      = (state_q == StWinner);
    assign bus_io.report_valid        = (state_q == StReport);

    assign bus_io.tally_1    = tally_1_q;
    assign bus_io.tally_2    = tally_2_q;
    assign bus_io.tally_3    = tally_3_q;
    assign bus_io.winner_id  = winner_q;
    assign bus_io.tie_flag   = tie_q;
    assign bus_io.admitted   = admitted_q;
    assign bus_io.abandoned  = abandoned_q;
    assign bus_io.autoclosed = autoclosed_q;
    assign bus_io.error      = error_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Directed bench for evm_ballot_controller with a behavioural evm model and a
// report scoreboard.
module tb_evm_ballot_controller;
    import evm_pkg::*;

    localparam int unsigned WIDTH = 7;

    typedef struct packed {
        logic [WIDTH-1:0] t1;
        logic [WIDTH-1:0] t2;
        logic [WIDTH-1:0] t3;
        logic [1:0]       winner;
        logic             tie;
        logic [WIDTH-1:0] admitted;
        logic [WIDTH-1:0] abandoned;
        logic             autoclosed;
        logic             err;
    } rep_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    evm_ballot_controller_if #(.WIDTH(WIDTH)) bus ();

    evm_ballot_controller #(
        .WIDTH       (WIDTH),
        .TOKEN_BITS  (4),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    rep_t        exp_q[$];

    // ---------------- evm model ----------------
    logic             e_vip    = 1'b0;
    logic             e_done   = 1'b0;
    logic             e_mute   = 1'b0;  // ignore candidate_ready
    logic [WIDTH-1:0] e_t1     = '0;
    logic [WIDTH-1:0] e_t2     = '0;
    logic [WIDTH-1:0] e_t3     = '0;
    int unsigned      e_idle   = 0;
    int unsigned      e_vtimer = 0;
    logic [1:0]       vote_sel = 2'b00;
    logic [WIDTH-1:0] e_max;
    int               n_top;

    always @(posedge clk) begin
        if (!bus.switch_on_evm) begin
            e_vip <= 1'b0; e_done <= 1'b0; e_idle <= 0; e_vtimer <= 0;
            e_t1 <= '0; e_t2 <= '0; e_t3 <= '0;
        end else if (!e_done) begin
            if (bus.candidate_ready && !e_mute) begin
                e_vip <= 1'b1; e_vtimer <= 0; e_idle <= 0;
            end else if (e_vip) begin
                if (vote_sel != 2'b00) begin
                    e_vip <= 1'b0; e_idle <= 0;
                    if (vote_sel == CAND_1) e_t1 <= e_t1 + WIDTH'(1);
                    if (vote_sel == CAND_2) e_t2 <= e_t2 + WIDTH'(1);
                    if (vote_sel == CAND_3) e_t3 <= e_t3 + WIDTH'(1);
                end else if (e_vtimer == EVM_TIMER_MAX - 1) begin
                    e_vip <= 1'b0; e_idle <= 0;
                end else begin
                    e_vtimer <= e_vtimer + 1;
                end
            end else if (bus.voting_session_done) begin
                e_done <= 1'b1;
            end else if (e_idle == EVM_TIMER_MAX - 1) begin
                e_done <= 1'b1;
            end else begin
                e_idle <= e_idle + 1;
            end
        end
    end

    always_comb begin
        e_max = e_t1;
        if (e_t2 > e_max) e_max = e_t2;
        if (e_t3 > e_max) e_max = e_t3;
        n_top = 0;
        if (e_t1 == e_max) n_top = n_top + 1;
        if (e_t2 == e_max) n_top = n_top + 1;
        if (e_t3 == e_max) n_top = n_top + 1;
        bus.voting_in_progress = e_vip;
        bus.voting_done        = e_done;
        bus.invalid_results    = (n_top >= 2);
        bus.candidate_name     = (e_t1 == e_max) ? CAND_1 : (e_t2 == e_max) ? CAND_2 : CAND_3;
        case (bus.display_results)
            DISP_C1: bus.results = e_t1;
            DISP_C2: bus.results = e_t2;
            default: bus.results = e_t3;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rep_t mk(input int t1, input int t2, input int t3, input int w,
                                input int tie, input int adm, input int ab,
                                input int ac, input int er);
        rep_t r;
        r.t1 = WIDTH'(t1); r.t2 = WIDTH'(t2); r.t3 = WIDTH'(t3); r.winner = 2'(w);
        r.tie = 1'(tie); r.admitted = WIDTH'(adm); r.abandoned = WIDTH'(ab);
        r.autoclosed = 1'(ac); r.err = 1'(er);
        return r;
    endfunction

    task automatic pulse_start();
        bus.start_session = 1'b1; @(negedge clk); bus.start_session = 1'b0;
    endtask

    task automatic pulse_token();
        bus.voter_token = 1'b1; @(negedge clk); bus.voter_token = 1'b0;
    endtask

    task automatic pulse_close();
        bus.close_session = 1'b1; @(negedge clk); bus.close_session = 1'b0;
    endtask

    task automatic wait_vip(input logic lvl, input int bound, input string tag);
        int k = 0;
        while (bus.voting_in_progress !== lvl && k < bound) begin
            @(negedge clk); k++;
        end
        check({tag, " vip level"}, 32'(bus.voting_in_progress), 32'(lvl));
    endtask

    task automatic cast_vote(input logic [1:0] c, input string tag);
        wait_vip(1'b1, 20, tag);
        vote_sel = c; @(negedge clk); vote_sel = 2'b00;
        wait_vip(1'b0, 20, tag);
    endtask

    task automatic check_report(input string tag, input int bound);
        rep_t e;
        int   k = 0;
        while (bus.report_valid !== 1'b1 && k < bound) begin
            @(negedge clk); k++;
        end
        check({tag, " report_valid"}, 32'(bus.report_valid), 32'd1);
        e = exp_q.pop_front();
        check({tag, " tally_1"},    32'(bus.tally_1),    32'(e.t1));
        check({tag, " tally_2"},    32'(bus.tally_2),    32'(e.t2));
        check({tag, " tally_3"},    32'(bus.tally_3),    32'(e.t3));
        check({tag, " winner_id"},  32'(bus.winner_id),  32'(e.winner));
        check({tag, " tie_flag"},   32'(bus.tie_flag),   32'(e.tie));
        check({tag, " admitted"},   32'(bus.admitted),   32'(e.admitted));
        check({tag, " abandoned"},  32'(bus.abandoned),  32'(e.abandoned));
        check({tag, " autoclosed"}, 32'(bus.autoclosed), 32'(e.autoclosed));
        check({tag, " error"},      32'(bus.error),      32'(e.err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        bus.start_session = 1'b0;
        bus.voter_token   = 1'b0;
        bus.close_session = 1'b0;
        repeat (3) @(negedge clk);
        check("rst switch_on",    32'(bus.switch_on_evm),   32'd0);
        check("rst cand_ready",   32'(bus.candidate_ready), 32'd0);
        check("rst report_valid", 32'(bus.report_valid),    32'd0);
        check("rst admitted",     32'(bus.admitted),        32'd0);
        check("rst error",        32'(bus.error),           32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: three voters, votes c1,c1,c2
        exp_q.push_back(mk(2, 1, 0, CAND_1, 0, 3, 0, 0, 0));
        pulse_start();
        check("s1 pwrup switch_on", 32'(bus.switch_on_evm), 32'd1);
        pulse_token(); pulse_token(); pulse_token();
        pulse_start();  // ignored mid-session
        cast_vote(CAND_1, "s1 v1");
        cast_vote(CAND_1, "s1 v2");
        cast_vote(CAND_2, "s1 v3");
        pulse_close();
        check_report("s1", 50);
        pulse_token();  // ignored in REPORT; would show up as an extra admission in s2

        // 2: voter walks away; evm vote timeout
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
        pulse_start();
        check("s2 pwroff switch_on", 32'(bus.switch_on_evm), 32'd0);
        @(negedge clk);
        check("s2 cleared tally_1", 32'(bus.tally_1), 32'd0);
        check("s2 cleared admitted", 32'(bus.admitted), 32'd0);
        pulse_token();
        wait_vip(1'b1, 20, "s2 rise");
        wait_vip(1'b0, 150, "s2 vote timeout");
        pulse_close();
        check_report("s2", 50);

        // 3: nothing happens; evm closes itself
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
        pulse_start();
        check_report("s3", 300);

        // 4: c2,c3 tie; close latched during the second vote. Tallies report
        // zero under a tie, so both admissions count as abandoned.
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2, 2, 0, 0));
        pulse_start();
        pulse_token(); pulse_token();
        cast_vote(CAND_2, "s4 v1");
        wait_vip(1'b1, 20, "s4 v2 rise");
        pulse_close();
        cast_vote(CAND_3, "s4 v2");
        check_report("s4", 50);

        // handshake timeout: evm ignores the admit pulse
        pulse_start();
        e_mute = 1'b1;
        pulse_token();
        k = 0;
        while (bus.error !== 1'b1 && k < 30) begin
            @(negedge clk); k++;
        end
        check("ack timeout error", 32'(bus.error), 32'd1);
        check("ack timeout admitted", 32'(bus.admitted), 32'd1);
        e_mute = 1'b0;

        // 5: token saturation during WAITV, token + ADMIT holds
        pulse_token();
        wait_vip(1'b1, 20, "s5 rise");
        bus.voter_token = 1'b1;
        repeat (17) @(negedge clk);
        bus.voter_token = 1'b0;
        check("s5 pending saturated", 32'(dut.u_token_counter.count_o), 32'd15);
        cast_vote(CAND_1, "s5 v1");
        k = 0;
        while (bus.candidate_ready !== 1'b1 && k < 10) begin
            @(negedge clk); k++;
        end
        check("s5 admit seen", 32'(bus.candidate_ready), 32'd1);
        pulse_token();
        check("s5 token+admit hold", 32'(dut.u_token_counter.count_o), 32'd15);
        check("s5 admitted", 32'(bus.admitted), 32'd3);
        check("s5 error sticky", 32'(bus.error), 32'd1);

        // 6: reset mid-WAITV
        rst = 1'b1;
        @(negedge clk);
        check("s6 switch_on", 32'(bus.switch_on_evm), 32'd0);
        check("s6 admitted", 32'(bus.admitted), 32'd0);
        check("s6 error", 32'(bus.error), 32'd0);
        check("s6 report_valid", 32'(bus.report_valid), 32'd0);
        check("s6 pending", 32'(dut.u_token_counter.count_o), 32'd0);
        @(negedge clk);
        check("s6 evm idle", 32'(e_vip), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
